// File: rtl/warp_pkg.sv
// Shared warp-level defaults for the warp memory datapath.
package warp_pkg;

  localparam int unsigned NUM_LANES_DEFAULT = 4;
  localparam int unsigned ADDR_WIDTH        = 32;

endpackage

// File: rtl/warp_mem_arbiter.sv
// Arbitrates the single L1 memory port between warp fetch (fixed priority) and
// round-robin lane load/stores, routing in-order read responses back by tag.
module warp_mem_arbiter #(
  parameter int unsigned NUM_LANES       = warp_pkg::NUM_LANES_DEFAULT,
  parameter int unsigned ADDR_WIDTH      = warp_pkg::ADDR_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            fetch_req_valid,
  output logic                            fetch_req_ready,
  input  logic [ADDR_WIDTH-1:0]           fetch_req_addr,
  output logic                            fetch_resp_valid,
  input  logic [NUM_LANES-1:0]            lane_req_valid,
  output logic [NUM_LANES-1:0]            lane_req_ready,
  input  logic [NUM_LANES*ADDR_WIDTH-1:0] lane_req_addr,
  input  logic [NUM_LANES-1:0]            lane_req_write,
  input  logic [NUM_LANES*32-1:0]         lane_req_data,
  output logic [NUM_LANES-1:0]            lane_resp_valid,
  output logic [31:0]                     resp_data,
  output logic                            mem_req_valid,
  input  logic                            mem_req_ready,
  output logic [ADDR_WIDTH-1:0]           mem_req_addr,
  output logic                            mem_req_write,
  output logic [31:0]                     mem_req_data,
  input  logic                            mem_resp_valid,
  output logic                            mem_resp_ready,
  input  logic [31:0]                     mem_resp_data,
  output logic                            busy,
  output logic                            spurious_resp
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAG_W  = $clog2(NUM_LANES + 1);
  localparam int unsigned LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int unsigned PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);

  logic [LANE_W-1:0]     rr_q, rr_d;
  logic [TAG_W-1:0]      tag_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  busy_q;
  logic                  spurious_q;

  logic                  lane_found;
  logic [LANE_W-1:0]     lane_sel;
  logic                  win_valid;
  logic                  win_read;
  logic                  win_write;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_W-1:0]     win_data;
  logic [TAG_W-1:0]      win_tag;
  logic [TAG_W-1:0]      head_tag;
  logic                  fifo_full;
  logic                  issue;
  logic                  grant;
  logic                  push;
  logic                  pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : PTR_W'(32'(p) + 1);
  endfunction

  // First requesting lane at or after the round-robin pointer, with wrap.
  always_comb begin : lane_search
    int unsigned idx;
    idx        = 0;
    lane_found = 1'b0;
    lane_sel   = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      idx = (32'(rr_q) + k) % NUM_LANES;
      if (!lane_found && lane_req_valid[LANE_W'(idx)]) begin
        lane_found = 1'b1;
        lane_sel   = LANE_W'(idx);
      end
    end
  end

  // Winner mux and issue/stall decision; fullness uses the registered count only.
  always_comb begin : winner_mux
    win_valid = fetch_req_valid || lane_found;
    win_read  = 1'b1;
    win_write = 1'b0;
    win_addr  = fetch_req_addr;
    win_data  = '0;
    win_tag   = '0;
    if (!fetch_req_valid) begin
      win_write = lane_req_write[lane_sel];
      win_read  = !lane_req_write[lane_sel];
      win_addr  = lane_req_addr[32'(lane_sel)*ADDR_WIDTH +: ADDR_WIDTH];
      win_data  = lane_req_data[32'(lane_sel)*DATA_W +: DATA_W];
      win_tag   = TAG_W'(32'(lane_sel) + 1);
    end
    fifo_full = (count_q == CNT_W'(MAX_OUTSTANDING));
    issue     = win_valid && !(win_read && fifo_full);
    grant     = issue && mem_req_ready;
    push      = grant && win_read;
    pop       = mem_resp_valid && (count_q != '0);
    head_tag  = tag_q[rd_ptr_q];
  end

  // Port drive; reset forces every handshake and payload output low.
  always_comb begin : port_drive
    mem_req_valid    = rst_n && issue;
    mem_req_addr     = '0;
    mem_req_write    = 1'b0;
    mem_req_data     = '0;
    fetch_req_ready  = 1'b0;
    lane_req_ready   = '0;
    fetch_resp_valid = 1'b0;
    lane_resp_valid  = '0;
    resp_data        = '0;
    mem_resp_ready   = rst_n;
    busy             = busy_q;
    spurious_resp    = spurious_q;
    if (rst_n && issue) begin
      mem_req_addr  = win_addr;
      mem_req_write = win_write;
      mem_req_data  = win_data;
    end
    if (rst_n && grant) begin
      if (fetch_req_valid) fetch_req_ready = 1'b1;
      else                 lane_req_ready[lane_sel] = 1'b1;
    end
    if (rst_n && pop) begin
      resp_data        = mem_resp_data;
      fetch_resp_valid = (head_tag == '0);
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        lane_resp_valid[i] = (head_tag == TAG_W'(i + 1));
      end
    end
  end

  // Next count and round-robin pointer.
  always_comb begin : next_state
    count_d = count_q;
    rr_d    = rr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (grant && !fetch_req_valid) begin
      rr_d = LANE_W'((32'(lane_sel) + 1) % NUM_LANES);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      spurious_q <= 1'b0;
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      rr_q    <= rr_d;
      count_q <= count_d;
      busy_q  <= (count_d != '0);
      if (push) begin
        tag_q[wr_ptr_q] <= win_tag;
        wr_ptr_q        <= ptr_next(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_next(rd_ptr_q);
      end
      if (mem_resp_valid && (count_q == '0)) begin
        spurious_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_warp_mem_arbiter.sv
// Self-checking bench for warp_mem_arbiter: directed vector table, reset
// sequences, and randomized traffic against a queue-based reference model.
module tb_warp_mem_arbiter;

  localparam int NL   = 4;
  localparam int AW   = 32;
  localparam int MO   = 2;
  localparam int FET  = -1;
  localparam int NONE = -2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            fetch_req_valid;
  logic            fetch_req_ready;
  logic [AW-1:0]   fetch_req_addr;
  logic            fetch_resp_valid;
  logic [NL-1:0]   lane_req_valid;
  logic [NL-1:0]   lane_req_ready;
  logic [NL*AW-1:0] lane_req_addr;
  logic [NL-1:0]   lane_req_write;
  logic [NL*32-1:0] lane_req_data;
  logic [NL-1:0]   lane_resp_valid;
  logic [31:0]     resp_data;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [AW-1:0]   mem_req_addr;
  logic            mem_req_write;
  logic [31:0]     mem_req_data;
  logic            mem_resp_valid;
  logic            mem_resp_ready;
  logic [31:0]     mem_resp_data;
  logic            busy;
  logic            spurious_resp;

  logic [31:0] faddr;
  logic [31:0] laddr [NL];
  logic [31:0] ldata [NL];

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit        fv;
    bit [3:0]  lv;
    bit [3:0]  lw;
    bit        mrdy;
    bit        rv;
    bit [31:0] rdata;
    int        e_win;
    bit        e_mv;
    int        e_resp;
    bit        e_busy;
    bit        e_spur;
  } vec_t;

  vec_t tbl[$];
  vec_t rst_seq[$];

  // Reference model state
  int q[$];
  int rr;
  bit spur;

  always #5 clk = ~clk;

  always_comb begin
    fetch_req_addr = faddr;
    for (int i = 0; i < NL; i++) begin
      lane_req_addr[i*AW +: AW] = laddr[i];
      lane_req_data[i*32 +: 32] = ldata[i];
    end
  end

  warp_mem_arbiter #(
    .NUM_LANES       (NL),
    .ADDR_WIDTH      (AW),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fetch_req_valid  (fetch_req_valid),
    .fetch_req_ready  (fetch_req_ready),
    .fetch_req_addr   (fetch_req_addr),
    .fetch_resp_valid (fetch_resp_valid),
    .lane_req_valid   (lane_req_valid),
    .lane_req_ready   (lane_req_ready),
    .lane_req_addr    (lane_req_addr),
    .lane_req_write   (lane_req_write),
    .lane_req_data    (lane_req_data),
    .lane_resp_valid  (lane_resp_valid),
    .resp_data        (resp_data),
    .mem_req_valid    (mem_req_valid),
    .mem_req_ready    (mem_req_ready),
    .mem_req_addr     (mem_req_addr),
    .mem_req_write    (mem_req_write),
    .mem_req_data     (mem_req_data),
    .mem_resp_valid   (mem_resp_valid),
    .mem_resp_ready   (mem_resp_ready),
    .mem_resp_data    (mem_resp_data),
    .busy             (busy),
    .spurious_resp    (spurious_resp)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  task automatic drive_idle();
    fetch_req_valid = 1'b0;
    lane_req_valid  = '0;
    lane_req_write  = '0;
    mem_req_ready   = 1'b1;
    mem_resp_valid  = 1'b0;
    mem_resp_data   = '0;
  endtask

  // Compare every output against the expected winner / response identity.
  task automatic check_outputs(input int e_win, input bit e_mv, input int e_resp,
                               input bit e_busy, input bit e_spur);
    logic [31:0] ea;
    logic [31:0] ed;
    logic        ew;
    logic [3:0]  elr;
    logic [3:0]  elresp;
    ea = '0; ed = '0; ew = 1'b0;
    if (e_mv) begin
      if (e_win == FET) ea = faddr;
      else begin
        ea = laddr[e_win];
        ed = ldata[e_win];
        ew = lane_req_write[e_win];
      end
    end
    elr    = (e_mv && mem_req_ready && e_win >= 0) ? 4'(1 << e_win) : 4'b0;
    elresp = (e_resp >= 0) ? 4'(1 << e_resp) : 4'b0;
    chk("mem_req_valid",   32'(mem_req_valid),   32'(e_mv));
    chk("mem_req_addr",    mem_req_addr,         ea);
    chk("mem_req_write",   32'(mem_req_write),   32'(ew));
    chk("mem_req_data",    mem_req_data,         ed);
    chk("fetch_req_ready", 32'(fetch_req_ready), 32'(e_mv && mem_req_ready && e_win == FET));
    chk("lane_req_ready",  32'(lane_req_ready),  32'(elr));
    chk("fetch_resp_valid", 32'(fetch_resp_valid), 32'(e_resp == FET));
    chk("lane_resp_valid", 32'(lane_resp_valid), 32'(elresp));
    if (e_resp != NONE) chk("resp_data", resp_data, mem_resp_data);
    chk("mem_resp_ready",  32'(mem_resp_ready),  32'd1);
    chk("busy",            32'(busy),            32'(e_busy));
    chk("spurious_resp",   32'(spurious_resp),   32'(e_spur));
  endtask

  // In reset every handshake and payload output is low, even with live inputs.
  task automatic check_reset();
    chk("rst_mem_req_valid",   32'(mem_req_valid),    32'd0);
    chk("rst_mem_req_addr",    mem_req_addr,          32'd0);
    chk("rst_mem_req_data",    mem_req_data,          32'd0);
    chk("rst_fetch_req_ready", 32'(fetch_req_ready),  32'd0);
    chk("rst_lane_req_ready",  32'(lane_req_ready),   32'd0);
    chk("rst_fetch_resp",      32'(fetch_resp_valid), 32'd0);
    chk("rst_lane_resp",       32'(lane_resp_valid),  32'd0);
    chk("rst_resp_data",       resp_data,             32'd0);
    chk("rst_mem_resp_ready",  32'(mem_resp_ready),   32'd0);
    chk("rst_busy",            32'(busy),             32'd0);
    chk("rst_spurious",        32'(spurious_resp),    32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    fetch_req_valid = v.fv;
    lane_req_valid  = v.lv;
    lane_req_write  = v.lw;
    mem_req_ready   = v.mrdy;
    mem_resp_valid  = v.rv;
    mem_resp_data   = v.rdata;
    #1;
    check_outputs(v.e_win, v.e_mv, v.e_resp, v.e_busy, v.e_spur);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n           = 1'b0;
    fetch_req_valid = 1'b1;
    lane_req_valid  = 4'b1111;
    mem_req_ready   = 1'b1;
    mem_resp_valid  = 1'b1;
    mem_resp_data   = 32'hCAFE_F00D;
    #1;
    check_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive_idle();
  endtask

  // One randomized cycle: derive expectations from the queue model, then advance it.
  task automatic random_cycle();
    int  win;
    bit  rd;
    bit  mv;
    int  e_resp;
    @(negedge clk);
    fetch_req_valid = ($urandom_range(0, 3) == 0);
    lane_req_valid  = 4'($urandom);
    lane_req_write  = 4'($urandom);
    mem_req_ready   = ($urandom_range(0, 3) != 0);
    mem_resp_valid  = ($urandom_range(0, 2) == 0);
    mem_resp_data   = $urandom;
    faddr           = $urandom;
    for (int i = 0; i < NL; i++) begin
      laddr[i] = $urandom;
      ldata[i] = $urandom;
    end
    #1;
    win = NONE;
    if (fetch_req_valid) win = FET;
    else begin
      for (int j = 0; j < NL; j++) begin
        if (win == NONE && lane_req_valid[(rr + j) % NL]) win = (rr + j) % NL;
      end
    end
    rd     = (win == FET) || (win >= 0 && !lane_req_write[win]);
    mv     = (win != NONE) && !(rd && q.size() == MO);
    e_resp = (mem_resp_valid && q.size() > 0) ? q[0] : NONE;
    check_outputs(win, mv, e_resp, q.size() != 0, spur);
    if (mem_resp_valid) begin
      if (q.size() > 0) void'(q.pop_front());
      else spur = 1'b1;
    end
    if (mv && mem_req_ready) begin
      if (rd) q.push_back(win);
      if (win >= 0) rr = (win + 1) % NL;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    faddr = 32'h0000_0040;
    for (int i = 0; i < NL; i++) begin
      laddr[i] = 32'h0000_0080 + 32'(i) * 32'h40;
      ldata[i] = 32'hD000_0000 + 32'(i);
    end
    fetch_req_valid = 1'b1;
    lane_req_valid  = 4'b1111;
    lane_req_write  = '0;
    mem_req_ready   = 1'b1;
    mem_resp_valid  = 1'b1;
    mem_resp_data   = 32'h1234_5678;

    //          fv lv       lw       rdy rv rdata          win  mv resp busy spur
    tbl.push_back('{0, 4'b0100, 4'b0000, 1, 0, 32'h0,        2,    1, NONE, 0, 0});
    tbl.push_back('{0, 4'b0000, 4'b0000, 1, 1, 32'hDEADBEEF, NONE, 0, 2,    1, 0});
    tbl.push_back('{0, 4'b0000, 4'b0000, 1, 0, 32'h0,        NONE, 0, NONE, 0, 0});
    tbl.push_back('{1, 4'b0010, 4'b0000, 1, 0, 32'h0,        FET,  1, NONE, 0, 0});
    tbl.push_back('{0, 4'b0010, 4'b0000, 1, 0, 32'h0,        1,    1, NONE, 1, 0});
    tbl.push_back('{0, 4'b0000, 4'b0000, 1, 1, 32'h0000000A, NONE, 0, FET,  1, 0});
    tbl.push_back('{0, 4'b0000, 4'b0000, 1, 1, 32'h0000000B, NONE, 0, 1,    1, 0});
    tbl.push_back('{0, 4'b1000, 4'b1000, 1, 0, 32'h0,        3,    1, NONE, 0, 0});
    for (int k = 0; k < 8; k++)
      tbl.push_back('{0, 4'b1111, 4'b1111, 1, 0, 32'h0,      k % 4, 1, NONE, 0, 0});
    tbl.push_back('{0, 4'b0111, 4'b0000, 1, 0, 32'h0,        0,    1, NONE, 0, 0});
    tbl.push_back('{0, 4'b0110, 4'b0000, 1, 0, 32'h0,        1,    1, NONE, 1, 0});
    tbl.push_back('{0, 4'b0100, 4'b0000, 1, 0, 32'h0,        2,    0, NONE, 1, 0});
    tbl.push_back('{0, 4'b0100, 4'b0000, 1, 1, 32'h00000055, 2,    0, 0,    1, 0});
    tbl.push_back('{0, 4'b0100, 4'b0000, 0, 0, 32'h0,        2,    1, NONE, 1, 0});
    tbl.push_back('{0, 4'b0100, 4'b0000, 1, 0, 32'h0,        2,    1, NONE, 1, 0});
    tbl.push_back('{0, 4'b0000, 4'b0000, 1, 1, 32'h00000066, NONE, 0, 1,    1, 0});
    tbl.push_back('{0, 4'b0000, 4'b0000, 1, 1, 32'h00000077, NONE, 0, 2,    1, 0});
    tbl.push_back('{0, 4'b0000, 4'b0000, 1, 1, 32'h00000099, NONE, 0, NONE, 0, 0});
    tbl.push_back('{0, 4'b0000, 4'b0000, 1, 0, 32'h0,        NONE, 0, NONE, 0, 1});
    tbl.push_back('{0, 4'b0000, 4'b0000, 1, 0, 32'h0,        NONE, 0, NONE, 0, 1});
    tbl.push_back('{0, 4'b1000, 4'b0000, 1, 0, 32'h0,        3,    1, NONE, 0, 1});
    tbl.push_back('{0, 4'b0010, 4'b0000, 1, 0, 32'h0,        1,    1, NONE, 1, 1});

    rst_seq.push_back('{0, 4'b1001, 4'b0000, 1, 1, 32'h00000012, 0,    1, NONE, 0, 0});
    rst_seq.push_back('{0, 4'b1000, 4'b0000, 1, 0, 32'h0,        3,    1, NONE, 1, 1});
    rst_seq.push_back('{0, 4'b0000, 4'b0000, 1, 1, 32'h00000021, NONE, 0, 0,    1, 1});
    rst_seq.push_back('{0, 4'b0000, 4'b0000, 1, 1, 32'h00000034, NONE, 0, 3,    1, 1});
    rst_seq.push_back('{0, 4'b0000, 4'b0000, 1, 0, 32'h0,        NONE, 0, NONE, 0, 1});

    #1;
    check_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive_idle();

    foreach (tbl[i]) run_vec(tbl[i]);

    // Mid-operation reset with two reads in flight and spurious_resp set.
    pulse_reset();
    foreach (rst_seq[i]) run_vec(rst_seq[i]);

    pulse_reset();
    q.delete();
    rr   = 0;
    spur = 1'b0;
    for (int n = 0; n < 1500; n++) random_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
